// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3), one input bit per clock.
// Result is register-held between conversions and saturates to 9999 on overflow.
module bin_to_bcd_seq #(
  parameter int BIN_WIDTH = 14
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 START,
  input  logic [BIN_WIDTH-1:0] BIN,
  output logic                 BUSY,
  output logic                 DONE,
  output logic                 OVF,
  output logic [15:0]          BCD
);

  localparam int            CW   = $clog2(BIN_WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(BIN_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01
  } state_t;

  state_t               state, state_n;
  logic [CW-1:0]        count, count_n;
  logic [BIN_WIDTH-1:0] bin_reg, bin_reg_n;
  logic [19:0]          scratch, scratch_n, shifted;
  logic [18:0]          adjusted;
  logic                 ovf_pending, ovf_pending_n;
  logic                 busy_n, done_n, ovf_n;
  logic [15:0]          bcd_n;
  logic                 bin_over;

  assign bin_over = {{(17-BIN_WIDTH){1'b0}}, BIN} > 17'd9999;

  // Digit 4 only needs its low three bits: its MSB is shifted out and never observed.
  always_comb begin
    adjusted = '0;
    for (int i = 0; i < 4; i++) begin
      adjusted[4*i +: 4] = (scratch[4*i +: 4] >= 4'd5) ? scratch[4*i +: 4] + 4'd3
                                                      : scratch[4*i +: 4];
    end
    adjusted[18:16] = (scratch[19:16] >= 4'd5) ? scratch[18:16] + 3'd3 : scratch[18:16];
  end

  assign shifted = {adjusted, bin_reg[BIN_WIDTH-1]};

  always_comb begin
    state_n       = state;
    count_n       = count;
    bin_reg_n     = bin_reg;
    scratch_n     = scratch;
    ovf_pending_n = ovf_pending;
    busy_n        = BUSY;
    done_n        = 1'b0;
    ovf_n         = OVF;
    bcd_n         = BCD;
    case (state)
      IDLE: begin
        if (START) begin
          bin_reg_n     = BIN;
          scratch_n     = '0;
          ovf_pending_n = bin_over;
          count_n       = '0;
          busy_n        = 1'b1;
          state_n       = SHIFT;
        end
      end
      SHIFT: begin
        scratch_n = shifted;
        bin_reg_n = bin_reg << 1;
        count_n   = count + CW'(1);
        if (count == LAST) begin
          bcd_n   = ovf_pending ? 16'h9999 : shifted[15:0];
          ovf_n   = ovf_pending;
          done_n  = 1'b1;
          busy_n  = 1'b0;
          state_n = IDLE;
        end
      end
      default: begin
        busy_n  = 1'b0;
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= IDLE;
      count       <= '0;
      bin_reg     <= '0;
      scratch     <= '0;
      ovf_pending <= 1'b0;
      BUSY        <= 1'b0;
      DONE        <= 1'b0;
      OVF         <= 1'b0;
      BCD         <= 16'h0000;
    end else begin
      state       <= state_n;
      count       <= count_n;
      bin_reg     <= bin_reg_n;
      scratch     <= scratch_n;
      ovf_pending <= ovf_pending_n;
      BUSY        <= busy_n;
      DONE        <= done_n;
      OVF         <= ovf_n;
      BCD         <= bcd_n;
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq: directed boundary cases plus random
// conversions compared against a decimal-arithmetic reference model.
module tb_bin_to_bcd_seq;

  localparam int BW = 14;

  logic          CLK;
  logic          RST;
  logic          START;
  logic [BW-1:0] BIN;
  logic          BUSY;
  logic          DONE;
  logic          OVF;
  logic [15:0]   BCD;

  int          checks   = 0;
  int          failures = 0;
  logic [15:0] lastBcd  = 16'h0000;
  logic        lastOvf  = 1'b0;

  bin_to_bcd_seq #(.BIN_WIDTH(BW)) dut (
    .CLK   (CLK),
    .RST   (RST),
    .START (START),
    .BIN   (BIN),
    .BUSY  (BUSY),
    .DONE  (DONE),
    .OVF   (OVF),
    .BCD   (BCD)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Reference: saturate above 9999, otherwise plain decimal digit extraction.
  function automatic logic [15:0] expBcd(input int v);
    logic [15:0] r;
    if (v > 9999) r = 16'h9999;
    else begin
      r[15:12] = 4'((v / 1000) % 10);
      r[11:8]  = 4'((v / 100) % 10);
      r[7:4]   = 4'((v / 10) % 10);
      r[3:0]   = 4'(v % 10);
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      checkOutput("idle_busy", 32'(BUSY), 32'd0);
      checkOutput("idle_done", 32'(DONE), 32'd0);
      checkOutput("idle_bcd", 32'(BCD), 32'(lastBcd));
      checkOutput("idle_ovf", 32'(OVF), 32'(lastOvf));
    end
  endtask

  // One full conversion; intfK>0 raises START with intfVal while busy.
  task automatic applyStimulus(input int value, input int intfK, input int intfVal);
    logic [15:0] eb;
    logic        eo;
    eb = expBcd(value);
    eo = (value > 9999);
    BIN   = value[BW-1:0];
    START = 1'b1;
    tick();
    START = 1'b0;
    checkOutput("accept_busy", 32'(BUSY), 32'd1);
    checkOutput("accept_done", 32'(DONE), 32'd0);
    for (int k = 1; k <= BW; k++) begin
      if (k == intfK) begin
        START = 1'b1;
        BIN   = intfVal[BW-1:0];
      end else begin
        START = 1'b0;
        BIN   = BW'($urandom);
      end
      tick();
      if (k < BW) begin
        checkOutput("busy_held", 32'(BUSY), 32'd1);
        checkOutput("no_early_done", 32'(DONE), 32'd0);
        checkOutput("bcd_held", 32'(BCD), 32'(lastBcd));
      end else begin
        checkOutput("done_pulse", 32'(DONE), 32'd1);
        checkOutput("busy_drop", 32'(BUSY), 32'd0);
        checkOutput("bcd_result", 32'(BCD), 32'(eb));
        checkOutput("ovf_result", 32'(OVF), 32'(eo));
      end
    end
    START   = 1'b0;
    lastBcd = eb;
    lastOvf = eo;
  endtask

  initial begin
    int v;
    int ik;
    RST   = 1'b1;
    START = 1'b0;
    BIN   = '0;
    tick();
    tick();
    checkOutput("reset_bcd", 32'(BCD), 32'd0);
    checkOutput("reset_busy", 32'(BUSY), 32'd0);
    checkOutput("reset_done", 32'(DONE), 32'd0);
    checkOutput("reset_ovf", 32'(OVF), 32'd0);
    RST = 1'b0;
    idleCycles(50);

    applyStimulus(1234, 0, 0);
    idleCycles(3);
    applyStimulus(0, 0, 0);
    idleCycles(2);
    applyStimulus(9999, 0, 0);
    idleCycles(2);
    applyStimulus(10000, 0, 0);
    idleCycles(2);
    applyStimulus(16383, 0, 0);
    idleCycles(2);

    applyStimulus(42, 5, 7);
    idleCycles(20);

    applyStimulus(305, 0, 0);
    applyStimulus(8000, 0, 0);
    idleCycles(3);

    applyStimulus(9876, 0, 0);
    idleCycles(2);
    BIN   = 14'd1111;
    START = 1'b1;
    tick();
    START = 1'b0;
    checkOutput("abort_accept_busy", 32'(BUSY), 32'd1);
    for (int k = 1; k <= 5; k++) begin
      tick();
      checkOutput("abort_busy_held", 32'(BUSY), 32'd1);
    end
    RST = 1'b1;
    tick();
    RST     = 1'b0;
    lastBcd = 16'h0000;
    lastOvf = 1'b0;
    checkOutput("abort_bcd", 32'(BCD), 32'd0);
    checkOutput("abort_busy", 32'(BUSY), 32'd0);
    checkOutput("abort_done", 32'(DONE), 32'd0);
    checkOutput("abort_ovf", 32'(OVF), 32'd0);
    idleCycles(20);
    applyStimulus(55, 0, 0);
    idleCycles(2);

    for (int n = 0; n < 30; n++) begin
      v  = int'($urandom_range(16383, 0));
      ik = int'($urandom_range(BW, 0));
      applyStimulus(v, ik, int'($urandom_range(16383, 0)));
      idleCycles(int'($urandom_range(2, 0)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
